usr_deserializer: RTL and testbench
===================================

Name: usr_deserializer

Overview:
- Receive-side companion to the universal shift register: takes the serial bit stream the USR shifts out and rebuilds parallel words.
- Supports MSB-first (shift-left) and LSB-first (shift-right) assembly, with word framing and a bit counter.
- Output register is double-buffered, with a valid/ready handshake and a sticky overrun flag.
- Sits between a USR serial output and any parallel consumer.

Parameters:
- WIDTH, 4, word width in bits; legal range is 2 or more.
- CNT_W, $clog2(WIDTH+1), width of the bit counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- sin  input  1  serial data bit.
- sin_valid  input  1  sin is sampled on this edge when high.
- dir  input  1  0 = MSB-first (shift-left assembly); 1 = LSB-first (shift-right assembly).
- frame_start  input  1  discards any partial word and starts a new word.
- pout  output  WIDTH  assembled word.
- pout_valid  output  1  pout holds an unconsumed word.
- out_ready  input  1  consumer accepts pout when pout_valid and out_ready are both high.
- busy  output  1  a partial word is in progress.
- bit_cnt  output  CNT_W  bits collected for the current word.
- overrun  output  1  sticky: a completed word was dropped.

Behaviour:
- Reset values: pout=0, pout_valid=0, busy=0, bit_cnt=0, overrun=0, shift register=0, state=IDLE, latched direction=0. Reset wins over all other inputs on the same edge.
- FSM state IDLE (bit_cnt=0, busy=0):
  - sin_valid=1: capture the bit, latch dir into dir_q, set bit_cnt=1, go to SHIFT.
- FSM state SHIFT (busy=1):
  - Each sin_valid=1 shifts in one bit and increments bit_cnt.
  - MSB-first (dir_q=0): sreg <= {sreg[WIDTH-2:0], sin}.
  - LSB-first (dir_q=1): sreg <= {sin, sreg[WIDTH-1:1]}.
  - sin_valid=0: hold sreg and bit_cnt.
- Direction:
  - dir is sampled only on the first bit of a word.
  - Changes to dir mid-word are ignored until the next word.
- Word completion (the edge that samples bit WIDTH):
  - The fully shifted value, including that bit, goes straight to pout.
  - bit_cnt returns to 0 and the FSM goes to IDLE.
  - pout_valid rises in the next cycle, so latency is 1 cycle from the last bit edge.
- Handshake:
  - pout_valid && out_ready clears pout_valid on that edge, unless a new word completes on the same edge.
  - pout and pout_valid stay stable while pout_valid=1 and out_ready=0.
- Simultaneous completion and accept: the new word loads, pout_valid stays 1, no overrun.
- Completion while pout_valid=1 and out_ready=0:
  - The new word is dropped and pout keeps the old word.
  - overrun is set to 1; it clears only on rst.
- frame_start=1:
  - The partial word is discarded and bit_cnt is cleared.
  - If sin_valid=1 on the same edge, that bit becomes bit 1 of a new word, dir is re-latched, and the FSM is in SHIFT.
  - Otherwise the FSM goes to IDLE.
  - pout and pout_valid are unaffected.
- Collection continues during an output hold; the double buffer allows back-to-back words with no bubble.
- Reset mid-word: the partial word is lost and all outputs return to their reset values on the next edge.

Decomposition:
- Package usr_pkg holds:
  - DIR_MSB_FIRST=1'b0 and DIR_LSB_FIRST=1'b1.
  - State encodings ST_IDLE and ST_SHIFT.
  - Shift-select codes shared with the USR: HOLD=2'b00, SHR=2'b01, SHL=2'b10, LOAD=2'b11.
- No sub-module is required. The shift/count datapath and the output buffer form a single module; a separate counter module adds nothing.

Test Plan:
- MSB-first: rst for 1 cycle; dir=0; sin_valid=1 with bits 0,1,0,1 on consecutive edges → pout=4'b0101, pout_valid=1 one cycle after the 4th bit, bit_cnt back to 0.
- LSB-first: dir=1; bits 1,0,1,0 → pout=4'b0101. Toggle dir to 0 after the 2nd bit → result unchanged (4'b0101).
- Backpressure: out_ready=0; send word 4'b1100 then word 4'b0011 → pout stays 4'b1100 and overrun=1. Set out_ready=1 → pout_valid clears next cycle; overrun stays 1 until rst.
- Same-edge accept and complete: hold pout_valid=1 with 4'b1010; assert out_ready on the edge of the 4th bit of 4'b0110 → pout=4'b0110, pout_valid=1, overrun=0.
- frame_start: send bits 1,1 then frame_start=1 with sin_valid=1, sin=0, then bits 0,0,1 (MSB-first) → pout=4'b0001; no word formed from the discarded 1,1.
- Reset mid-word: rst=1 after 2 bits → next cycle bit_cnt=0, busy=0, pout=0, pout_valid=0. Sin_valid gaps of 2 idle cycles between bits → same result as contiguous input.

Source files
------------

// File: rtl/usr_pkg.sv
// Shared constants for the universal shift register family: direction codes,
// deserializer FSM encodings and the USR shift-select codes.
package usr_pkg;

  localparam logic DIR_MSB_FIRST = 1'b0;
  localparam logic DIR_LSB_FIRST = 1'b1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  localparam logic [1:0] HOLD = 2'b00;
  localparam logic [1:0] SHR  = 2'b01;
  localparam logic [1:0] SHL  = 2'b10;
  localparam logic [1:0] LOAD = 2'b11;

endpackage

// File: rtl/usr_deserializer.sv
// Serial-to-parallel word assembler with MSB/LSB-first framing, a
// double-buffered output register, valid/ready handshake and sticky overrun.
module usr_deserializer
  import usr_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             dir,
  input  logic             frame_start,
  output logic [WIDTH-1:0] pout,
  output logic             pout_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             overrun
);

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] pout_q, pout_d;
  logic             pout_valid_q, pout_valid_d;
  logic             overrun_q, overrun_d;

  // A word starts fresh from IDLE or whenever framing restarts it.
  logic             fresh;
  logic             eff_dir;
  logic [WIDTH-1:0] sreg_base, sreg_shifted;
  logic [CNT_W-1:0] cnt_base, cnt_inc;
  logic             complete;
  logic             accept;

  always_comb begin
    fresh        = (state_q == ST_IDLE) || frame_start;
    eff_dir      = fresh ? dir : dir_q;
    sreg_base    = fresh ? '0 : sreg_q;
    cnt_base     = fresh ? '0 : cnt_q;
    cnt_inc      = cnt_base + 1'b1;
    sreg_shifted = (eff_dir == DIR_LSB_FIRST) ? {sin, sreg_base[WIDTH-1:1]}
                                              : {sreg_base[WIDTH-2:0], sin};
    complete     = sin_valid && (cnt_inc == CNT_W'(WIDTH));
    accept       = pout_valid_q && out_ready;
  end

  always_comb begin
    state_d      = state_q;
    sreg_d       = sreg_q;
    cnt_d        = cnt_q;
    dir_d        = dir_q;
    pout_d       = pout_q;
    pout_valid_d = pout_valid_q;
    overrun_d    = overrun_q;

    if (sin_valid) begin
      sreg_d = sreg_shifted;
      if (fresh) begin
        dir_d = dir;
      end
      if (complete) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        state_d = ST_SHIFT;
        cnt_d   = cnt_inc;
      end
    end else if (frame_start) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      sreg_d  = '0;
    end

    // Output buffer: a completing word may replace a word being accepted
    // on the same edge; otherwise a held word blocks it and flags overrun.
    if (complete) begin
      if (!pout_valid_q || out_ready) begin
        pout_d       = sreg_shifted;
        pout_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (accept) begin
      pout_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      sreg_q       <= '0;
      cnt_q        <= '0;
      dir_q        <= DIR_MSB_FIRST;
      pout_q       <= '0;
      pout_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sreg_q       <= sreg_d;
      cnt_q        <= cnt_d;
      dir_q        <= dir_d;
      pout_q       <= pout_d;
      pout_valid_q <= pout_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign pout       = pout_q;
  assign pout_valid = pout_valid_q;
  assign busy       = (state_q == ST_SHIFT);
  assign bit_cnt    = cnt_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_usr_deserializer.sv
// Scoreboard bench for usr_deserializer: stimulus pushes expected words, a
// monitor pops and compares each newly presented output word.
module tb_usr_deserializer;

  localparam int WIDTH = 4;
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             sin = 1'b0;
  logic             sin_valid = 1'b0;
  logic             dir = 1'b0;
  logic             frame_start = 1'b0;
  logic [WIDTH-1:0] pout;
  logic             pout_valid;
  logic             out_ready = 1'b1;
  logic             busy;
  logic [CNT_W-1:0] bit_cnt;
  logic             overrun;

  int total = 0;
  int bad = 0;
  logic [WIDTH-1:0] exp_q[$];

  usr_deserializer #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .sin        (sin),
    .sin_valid  (sin_valid),
    .dir        (dir),
    .frame_start(frame_start),
    .pout       (pout),
    .pout_valid (pout_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .bit_cnt    (bit_cnt),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after a rising edge.
  task automatic send_bit(input logic b, input logic d, input logic fs = 1'b0);
    sin         = b;
    dir         = d;
    sin_valid   = 1'b1;
    frame_start = fs;
    @(posedge clk);
    #1;
    sin_valid   = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: a word is new when valid appears after an idle or accepted cycle.
  logic prev_valid = 1'b0;
  logic prev_acc = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_valid <= 1'b0;
      prev_acc   <= 1'b0;
    end else begin
      if (pout_valid && (!prev_valid || prev_acc)) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_word: got %0h expected none at %0t", pout, $time);
        end else begin
          chk("word", 32'(pout), 32'(exp_q.pop_front()));
        end
      end
      prev_valid <= pout_valid;
      prev_acc   <= pout_valid && out_ready;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin
    idle(1);
    do_reset();
    chk("rst_pout", 32'(pout), 0);
    chk("rst_valid", 32'(pout_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cnt", 32'(bit_cnt), 0);
    chk("rst_overrun", 32'(overrun), 0);

    // MSB-first 0,1,0,1 -> 0101
    exp_q.push_back(4'b0101);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    chk("msb_cnt2", 32'(bit_cnt), 2);
    chk("msb_busy", 32'(busy), 1);
    chk("msb_valid_early", 32'(pout_valid), 0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    chk("msb_valid", 32'(pout_valid), 1);
    chk("msb_cnt0", 32'(bit_cnt), 0);
    chk("msb_busy0", 32'(busy), 0);
    idle(2);

    // LSB-first 1,0,1,0 -> 0101
    exp_q.push_back(4'b0101);
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b1);
    idle(2);
    // dir toggled after 2nd bit is ignored
    exp_q.push_back(4'b0101);
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    idle(2);

    // Backpressure: 1100 held, 0011 dropped
    out_ready = 1'b0;
    exp_q.push_back(4'b1100);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    chk("bp_overrun0", 32'(overrun), 0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    chk("bp_pout", 32'(pout), 32'hC);
    chk("bp_valid", 32'(pout_valid), 1);
    chk("bp_overrun", 32'(overrun), 1);
    out_ready = 1'b1;
    idle(1);
    chk("bp_valid_clr", 32'(pout_valid), 0);
    chk("bp_overrun_sticky", 32'(overrun), 1);
    idle(3);
    chk("bp_overrun_sticky2", 32'(overrun), 1);
    do_reset();
    chk("bp_overrun_rst", 32'(overrun), 0);

    // Same-edge accept and complete
    out_ready = 1'b0;
    exp_q.push_back(4'b1010);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    idle(2);
    exp_q.push_back(4'b0110);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    out_ready = 1'b1;
    send_bit(1'b0, 1'b0);
    chk("same_pout", 32'(pout), 32'h6);
    chk("same_valid", 32'(pout_valid), 1);
    chk("same_overrun", 32'(overrun), 0);
    idle(2);

    // frame_start discards 1,1 and restarts with bit 0
    exp_q.push_back(4'b0001);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0, 1'b1);
    chk("fs_cnt", 32'(bit_cnt), 1);
    chk("fs_busy", 32'(busy), 1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    idle(2);
    chk("fs_pout", 32'(pout), 32'h1);
    // frame_start alone returns to idle
    send_bit(1'b1, 1'b0);
    frame_start = 1'b1;
    idle(1);
    frame_start = 1'b0;
    chk("fs_idle_cnt", 32'(bit_cnt), 0);
    chk("fs_idle_busy", 32'(busy), 0);

    // Reset mid-word
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    do_reset();
    chk("mid_rst_cnt", 32'(bit_cnt), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_pout", 32'(pout), 0);
    chk("mid_rst_valid", 32'(pout_valid), 0);

    // Gapped input 1,0,1,1 -> 1011
    exp_q.push_back(4'b1011);
    send_bit(1'b1, 1'b0);
    idle(2);
    chk("gap_cnt1", 32'(bit_cnt), 1);
    send_bit(1'b0, 1'b0);
    idle(2);
    chk("gap_cnt2", 32'(bit_cnt), 2);
    send_bit(1'b1, 1'b0);
    idle(2);
    send_bit(1'b1, 1'b0);
    idle(3);
    chk("gap_pout", 32'(pout), 32'hB);

    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
